wb_result_sel: RTL and testbench
================================

Name: wb_result_sel

Overview:
- Registered write-back result selector for the MIPS datapath; replaces the purely combinational R-type result mux.
- Owns the HI/LO architectural registers.
- Tracks an outstanding multi-cycle MULTU/DIVU operation and stalls dependent HI/LO accesses until the result returns.
- Sits between ALU/shifter/mul-div unit outputs and the register-file write port.

Parameters:
WIDTH, 32, datapath width of all data ports and HI/LO
FUNCT_W, 6, width of funct field

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instruction present this cycle
funct  input  FUNCT_W  R-type funct code
alu_in  input  WIDTH  ALU result
shift_in  input  WIDTH  shifter result
rs_in  input  WIDTH  rs operand (MTHI/MTLO source)
md_done  input  1  mul/div unit result valid (1-cycle pulse)
md_hi  input  WIDTH  mul/div high result (MULTU high word / DIVU remainder)
md_lo  input  WIDTH  mul/div low result (MULTU low word / DIVU quotient)
md_start  output  1  registered pulse: launch mul/div
stall  output  1  combinational: current instruction not accepted, hold upstream
data_out  output  WIDTH  registered write-back data
out_valid  output  1  registered: data_out valid this cycle
illegal  output  1  registered: unrecognised funct accepted
busy  output  1  mul/div outstanding
hi_q  output  WIDTH  HI register
lo_q  output  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): data_out=0, out_valid=0, illegal=0, md_start=0, hi_q=0, lo_q=0, state=IDLE, busy=0.
- Accept = in_valid & ~stall. Non-accepted cycles: out_valid=0 next cycle, no state change.
- Decode on accept; data_out and out_valid are registered, 1-cycle latency:
  - ALU (AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010): data_out<=alu_in.
  - Shifter (SLL 000000, SRL 000010): data_out<=shift_in.
  - MFHI 010000: data_out<=HI. MFLO 010010: data_out<=LO.
  - MTHI 010001: hi_q<=rs_in, data_out<=0. MTLO 010011: lo_q<=rs_in, data_out<=0.
  - MULTU 011001, DIVU 011011: data_out<=0; md_start pulses 1 cycle; state IDLE->BUSY.
  - Any other funct: data_out<=0, illegal<=1 for one cycle.
  - out_valid<=1 for every accepted instruction.
- State machine:
  - IDLE: busy=0.
  - IDLE -> BUSY on accepted MULTU/DIVU.
  - BUSY: busy=1.
  - BUSY -> IDLE on md_done; same edge hi_q<=md_hi, lo_q<=md_lo.
  - md_done in IDLE is ignored; HI/LO are unchanged.
- Stall (combinational) = in_valid & BUSY & ~md_done & funct in {MFHI, MFLO, MTHI, MTLO, MULTU, DIVU}. ALU/shift/illegal never stall.
- md_done bypass: in the md_done cycle an HI/LO-class instruction is accepted.
  - MFHI/MFLO forward md_hi/md_lo to data_out.
  - MTHI/MTLO rs_in write overrides the md result for that register; the other register takes the md value.
  - MULTU/DIVU re-enters BUSY and md_start pulses.
- All values are WIDTH bits; no width extension or truncation.
- Reset mid-operation: BUSY drops to IDLE; any later md_done is ignored.

Test Plan:
- Reset: rst=1 mid-run -> all outputs 0 immediately (asynchronous), hi_q=lo_q=0, busy=0.
- ADD, alu_in=0x0000_1234, in_valid=1 -> next cycle data_out=0x0000_1234, out_valid=1; SLL with shift_in=0x8000_0000 -> data_out=0x8000_0000.
- MTHI rs_in=0xDEAD_BEEF, then MFHI -> MFHI cycle data_out=0xDEAD_BEEF; MTLO 0x5, MFLO -> 0x5.
- MULTU accepted -> md_start pulse, busy=1, data_out=0. MFLO held 3 cycles -> stall=1 each cycle, out_valid=0. md_done with md_hi=0x1, md_lo=0xFFFF_FFFE -> MFLO accepted that cycle, next cycle data_out=0xFFFF_FFFE, hi_q=0x1, busy=0.
- While BUSY, ADD with alu_in=7 -> stall=0, data_out=7. Stray md_done in IDLE -> hi_q/lo_q unchanged.
- funct=111111 -> illegal=1, data_out=0, out_valid=1 for one cycle. WIDTH=16 build: MTHI 0xABCD, MFHI -> 0xABCD.

Source files
------------

// File: rtl/wb_result_sel.sv
// Registered write-back result selector with HI/LO ownership.
// Tracks one outstanding MULTU/DIVU and stalls HI/LO-class instructions until it returns.
module wb_result_sel #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   alu_in,
  input  logic [WIDTH-1:0]   shift_in,
  input  logic [WIDTH-1:0]   rs_in,
  input  logic               md_done,
  input  logic [WIDTH-1:0]   md_hi,
  input  logic [WIDTH-1:0]   md_lo,
  output logic               md_start,
  output logic               stall,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_valid,
  output logic               illegal,
  output logic               busy,
  output logic [WIDTH-1:0]   hi_q,
  output logic [WIDTH-1:0]   lo_q
);

  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_SRL   = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] F_MTHI  = FUNCT_W'(6'b010001);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] F_MTLO  = FUNCT_W'(6'b010011);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);
  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic [WIDTH-1:0]   data_r, hi_r, lo_r;
  logic               valid_r, ill_r, start_r;

  logic               hilo_op_s, md_ret_s, accept_s;
  logic [WIDTH-1:0]   hi_eff_s, lo_eff_s, hi_nxt_s, lo_nxt_s, data_nxt_s;
  logic               valid_nxt_s, ill_nxt_s, start_nxt_s;

  // Classify instructions that touch HI/LO or the mul/div unit.
  always_comb begin
    hilo_op_s = 1'b0;
    case (funct)
      F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_MULTU, F_DIVU: hilo_op_s = 1'b1;
      default:                                         hilo_op_s = 1'b0;
    endcase
  end

  assign busy     = (state_r == BUSY);
  assign md_ret_s = md_done & busy;
  assign stall    = in_valid & busy & ~md_done & hilo_op_s;
  assign accept_s = in_valid & ~stall;
  // A returning result is visible to the instruction accepted in the same cycle.
  assign hi_eff_s = md_ret_s ? md_hi : hi_r;
  assign lo_eff_s = md_ret_s ? md_lo : lo_r;

  // Decode the accepted instruction into next-state register values.
  always_comb begin
    state_nxt_s = md_ret_s ? IDLE : state_r;
    hi_nxt_s    = hi_eff_s;
    lo_nxt_s    = lo_eff_s;
    data_nxt_s  = data_r;
    valid_nxt_s = 1'b0;
    ill_nxt_s   = 1'b0;
    start_nxt_s = 1'b0;
    if (accept_s) begin
      valid_nxt_s = 1'b1;
      data_nxt_s  = '0;
      case (funct)
        F_ADD, F_SUB, F_AND, F_OR, F_SLT: data_nxt_s = alu_in;
        F_SLL, F_SRL:                     data_nxt_s = shift_in;
        F_MFHI:                           data_nxt_s = hi_eff_s;
        F_MFLO:                           data_nxt_s = lo_eff_s;
        F_MTHI:                           hi_nxt_s   = rs_in;
        F_MTLO:                           lo_nxt_s   = rs_in;
        F_MULTU, F_DIVU: begin
          start_nxt_s = 1'b1;
          state_nxt_s = BUSY;
        end
        default:                          ill_nxt_s  = 1'b1;
      endcase
    end else begin
      valid_nxt_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      data_r  <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      valid_r <= 1'b0;
      ill_r   <= 1'b0;
      start_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      valid_r <= valid_nxt_s;
      ill_r   <= ill_nxt_s;
      start_r <= start_nxt_s;
    end
  end

  assign data_out  = data_r;
  assign out_valid = valid_r;
  assign illegal   = ill_r;
  assign md_start  = start_r;
  assign hi_q      = hi_r;
  assign lo_q      = lo_r;

endmodule

// File: tb/tb_wb_result_sel.sv
// Self-checking bench for wb_result_sel: directed vector table, reset cases,
// randomized traffic against a rule-level model, and a 16-bit build check.
module tb_wb_result_sel;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, md_done, md_start, stall, out_valid, illegal, busy;
  logic [5:0]  funct;
  logic [31:0] alu_in, shift_in, rs_in, md_hi, md_lo, data_out, hi_q, lo_q;

  logic        in_valid16, md_start16, stall16, out_valid16, illegal16, busy16;
  logic [5:0]  funct16;
  logic [15:0] rs16, data16, hi16, lo16;

  always #5 clk = ~clk;

  wb_result_sel #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .funct(funct),
    .alu_in(alu_in), .shift_in(shift_in), .rs_in(rs_in),
    .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo),
    .md_start(md_start), .stall(stall), .data_out(data_out),
    .out_valid(out_valid), .illegal(illegal), .busy(busy),
    .hi_q(hi_q), .lo_q(lo_q)
  );

  wb_result_sel #(.WIDTH(16), .FUNCT_W(6)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .funct(funct16),
    .alu_in(16'h0000), .shift_in(16'h0000), .rs_in(rs16),
    .md_done(1'b0), .md_hi(16'h0000), .md_lo(16'h0000),
    .md_start(md_start16), .stall(stall16), .data_out(data16),
    .out_valid(out_valid16), .illegal(illegal16), .busy(busy16),
    .hi_q(hi16), .lo_q(lo16)
  );

  typedef struct {
    logic        iv;
    logic [5:0]  f;
    logic [31:0] alu, sh, rs;
    logic        done;
    logic [31:0] mh, ml;
    logic        e_stall, e_valid;
    logic [31:0] e_data;
    logic        e_ill, e_start, e_busy;
    logic [31:0] e_hi, e_lo;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Instruction classes: 0 ALU, 1 shift, 2 MFHI, 3 MFLO, 4 MTHI, 5 MTLO, 6 mul/div, 7 illegal
  int          cls [64];
  logic [5:0]  codes [13];

  logic [31:0] m_hi, m_lo, m_data;
  bit          m_busy, m_valid, m_ill, m_start;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = 32'h0; m_lo = 32'h0; m_data = 32'h0;
    m_busy = 1'b0; m_valid = 1'b0; m_ill = 1'b0; m_start = 1'b0;
  endtask

  task automatic step(input vec_t v, input bit tbl);
    bit          m_stall, acc, ret;
    logic [31:0] nh, nl;
    int          c;
    in_valid = v.iv; funct = v.f; alu_in = v.alu; shift_in = v.sh; rs_in = v.rs;
    md_done = v.done; md_hi = v.mh; md_lo = v.ml;
    @(negedge clk);
    c = cls[v.f];
    m_stall = v.iv && m_busy && !v.done && (c >= 2) && (c <= 6);
    chk("stall", 32'(stall), tbl ? 32'(v.e_stall) : 32'(m_stall));
    @(posedge clk);
    ret     = v.done && m_busy;
    nh      = ret ? v.mh : m_hi;
    nl      = ret ? v.ml : m_lo;
    acc     = v.iv && !m_stall;
    if (ret) m_busy = 1'b0;
    m_valid = acc;
    m_ill   = 1'b0;
    m_start = 1'b0;
    if (acc) begin
      m_data = 32'h0;
      case (c)
        0: m_data = v.alu;
        1: m_data = v.sh;
        2: m_data = nh;
        3: m_data = nl;
        4: nh = v.rs;
        5: nl = v.rs;
        6: begin m_start = 1'b1; m_busy = 1'b1; end
        default: m_ill = 1'b1;
      endcase
    end
    m_hi = nh;
    m_lo = nl;
    #1;
    chk("out_valid", 32'(out_valid), tbl ? 32'(v.e_valid) : 32'(m_valid));
    chk("data_out",  data_out,       tbl ? v.e_data       : m_data);
    chk("illegal",   32'(illegal),   tbl ? 32'(v.e_ill)   : 32'(m_ill));
    chk("md_start",  32'(md_start),  tbl ? 32'(v.e_start) : 32'(m_start));
    chk("busy",      32'(busy),      tbl ? 32'(v.e_busy)  : 32'(m_busy));
    chk("hi_q",      hi_q,           tbl ? v.e_hi         : m_hi);
    chk("lo_q",      lo_q,           tbl ? v.e_lo         : m_lo);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_data"},  data_out,        32'h0);
    chk({tag, "_valid"}, 32'(out_valid),  32'h0);
    chk({tag, "_ill"},   32'(illegal),    32'h0);
    chk({tag, "_start"}, 32'(md_start),   32'h0);
    chk({tag, "_busy"},  32'(busy),       32'h0);
    chk({tag, "_hi"},    hi_q,            32'h0);
    chk({tag, "_lo"},    lo_q,            32'h0);
  endtask

  vec_t tbl [27];

  initial begin
    vec_t v;
    for (int i = 0; i < 64; i++) cls[i] = 7;
    cls[6'h20] = 0; cls[6'h22] = 0; cls[6'h24] = 0; cls[6'h25] = 0; cls[6'h2A] = 0;
    cls[6'h00] = 1; cls[6'h02] = 1;
    cls[6'h10] = 2; cls[6'h12] = 3; cls[6'h11] = 4; cls[6'h13] = 5;
    cls[6'h19] = 6; cls[6'h1B] = 6;
    codes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02,
              6'h10, 6'h12, 6'h11, 6'h13, 6'h19, 6'h1B};

    //        iv    f      alu           sh            rs            done  mh            ml            stl   vld   data          ill   st    bsy   hi            lo
    tbl[0]  = '{1'b1, 6'h20, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 6'h00, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 6'h11, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0};
    tbl[3]  = '{1'b1, 6'h10, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0};
    tbl[4]  = '{1'b1, 6'h13, 32'h0, 32'h0, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h5};
    tbl[5]  = '{1'b1, 6'h12, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h5};
    tbl[6]  = '{1'b1, 6'h3F, 32'h77, 32'h66, 32'h55, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h5};
    tbl[7]  = '{1'b0, 6'h20, 32'h99, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h5};
    tbl[8]  = '{1'b1, 6'h19, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h5};
    tbl[9]  = '{1'b1, 6'h12, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h5};
    tbl[10] = '{1'b1, 6'h12, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h5};
    tbl[11] = '{1'b1, 6'h12, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h5};
    tbl[12] = '{1'b1, 6'h12, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'h1, 32'hFFFF_FFFE};
    tbl[13] = '{1'b1, 6'h19, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1, 32'hFFFF_FFFE};
    tbl[14] = '{1'b1, 6'h20, 32'h7, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7, 1'b0, 1'b0, 1'b1, 32'h1, 32'hFFFF_FFFE};
    tbl[15] = '{1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b1, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0, 32'hAAAA, 32'hBBBB};
    tbl[16] = '{1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1234, 32'h5678, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0, 32'hAAAA, 32'hBBBB};
    tbl[17] = '{1'b1, 6'h1B, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'hAAAA, 32'hBBBB};
    tbl[18] = '{1'b1, 6'h11, 32'h0, 32'h0, 32'h11, 1'b1, 32'h22, 32'h33, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h11, 32'h33};
    tbl[19] = '{1'b1, 6'h1B, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h11, 32'h33};
    tbl[20] = '{1'b1, 6'h19, 32'h0, 32'h0, 32'h0, 1'b1, 32'h4, 32'h5, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4, 32'h5};
    tbl[21] = '{1'b1, 6'h10, 32'h0, 32'h0, 32'h0, 1'b1, 32'h6, 32'h7, 1'b0, 1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 32'h6, 32'h7};
    tbl[22] = '{1'b1, 6'h02, 32'h0, 32'h0000_0F0F, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0F0F, 1'b0, 1'b0, 1'b0, 32'h6, 32'h7};
    tbl[23] = '{1'b1, 6'h22, 32'h99, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 32'h6, 32'h7};
    tbl[24] = '{1'b1, 6'h2A, 32'h1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h6, 32'h7};
    tbl[25] = '{1'b1, 6'h24, 32'h3, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 32'h6, 32'h7};
    tbl[26] = '{1'b1, 6'h25, 32'h4, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h6, 32'h7};

    rst = 1'b1;
    in_valid = 1'b0; funct = 6'h0; alu_in = 32'h0; shift_in = 32'h0; rs_in = 32'h0;
    md_done = 1'b0; md_hi = 32'h0; md_lo = 32'h0;
    in_valid16 = 1'b0; funct16 = 6'h0; rs16 = 16'h0;
    model_reset();
    #12;
    chk_reset_state("por");
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    for (int i = 0; i < 27; i++) step(tbl[i], 1'b1);

    // Reset asserted while a mul/div is outstanding
    v = tbl[8];
    step(v, 1'b0);
    in_valid = 1'b0; md_done = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_state("async_rst");
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    v = tbl[16];
    step(v, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      int k;
      v.iv  = ($urandom_range(0, 3) != 0);
      k     = int'($urandom_range(0, 15));
      v.f   = (k < 13) ? codes[k] : 6'($urandom_range(0, 63));
      v.alu = $urandom; v.sh = $urandom; v.rs = $urandom;
      v.done = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      v.mh  = $urandom; v.ml = $urandom;
      step(v, 1'b0);
    end

    in_valid = 1'b0; md_done = 1'b0;
    in_valid16 = 1'b1; funct16 = 6'h11; rs16 = 16'hABCD;
    @(posedge clk) #1;
    funct16 = 6'h10; rs16 = 16'h0;
    @(posedge clk) #1;
    in_valid16 = 1'b0;
    chk("w16_data",  32'(data16),      32'h0000_ABCD);
    chk("w16_hi",    32'(hi16),        32'h0000_ABCD);
    chk("w16_valid", 32'(out_valid16), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
